shfloat_block: RTL and testbench
================================

// Module: shfloat_block
// PURPOSE
//  Block-floating-point packer for I/Q sample streams; successor to the per-sample shared-exponent packer.
//  Collects up to BLOCK_LEN I/Q pairs and derives one exponent shared by the whole block.
//  Emits each pair as {I mantissa, Q mantissa, exponent}, with valid/ready handshakes on both sides.
//  Sits between the demodulator/accumulator output and the USB/serial frame packer.
// PARAMETERS
//  INPUT_DEPTH    32  signed width of in_value_i / in_value_q
//  MANTISSA_DEPTH 12  kept bits per component
//  EXPONENT_DEPTH  8  exponent field width; PACKED_DEPTH = 2*MANTISSA_DEPTH + EXPONENT_DEPTH
//  PACKED_DEPTH   32  output word width (elaboration error if inconsistent)
//  INDEX_DEPTH    32  sideband index width, passed through per sample
//  BLOCK_LEN       4  max samples per shared-exponent block (>=1)
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 reset; synchronous, active-high
//  in_index     in   INDEX_DEPTH       sample index
//  in_value_i   in   INPUT_DEPTH       signed I
//  in_value_q   in   INPUT_DEPTH       signed Q
//  in_last      in   1                 closes the block early (partial block)
//  in_valid     in   1                 input handshake
//  in_ready     out  1                 high only in FILL
//  out_index    out  INDEX_DEPTH       index of the emitted sample
//  out_pack     out  PACKED_DEPTH      [P-1 -: M]=I mant, [E+M-1 -: M]=Q mant, [E-1:0]=exp
//  out_last     out  1                 last word of the block
//  out_valid    out  1                 output handshake
//  out_ready    in   1                 downstream accept
//  out_exp      out  EXPONENT_DEPTH    debug copy of the block exponent
// BEHAVIOUR
//  Reset (sync, any state): state=FILL, count=0, mag_or=0, buffer contents discarded.
//   Outputs: out_valid=0, out_last=0, out_pack=0, out_index=0, out_exp=0; in_ready=1 on the next cycle.
//  FILL: a transfer occurs when in_valid&&in_ready. Each transfer:
//   - stores {index,i,q} at buffer[count] and increments count;
//   - updates mag_or |= abs(i)|abs(q), where abs(x) = x[MSB] ? ~x : x (one's complement).
//   - Go to NORM when count reaches BLOCK_LEN or in_last is set on the transfer.
//  NORM (exactly 1 cycle): exp = INPUT_DEPTH-1-bitlen(mag_or); bitlen(0)=0.
//   - exp is clamped to 2^EXPONENT_DEPTH-1, registered, and copied to out_exp.
//  DRAIN: words are emitted in arrival order. For each word:
//   - mant = (v<<<exp)[INPUT_DEPTH-1 -: MANTISSA_DEPTH], computed for I and Q;
//   - the word loads the output register when it is empty or out_ready=1.
//   - out_valid/out_pack/out_index/out_last are held stable while out_valid&&!out_ready.
//  Last word of the block: out_last=1. When it is accepted, count and mag_or clear and the state returns to FILL.
//  Latency: first out_valid is 2 clk after the edge that accepts the closing sample; then 1 word/clk if out_ready=1.
//  Simultaneous final-word accept and new in_valid: the new sample is not accepted that cycle (in_ready was 0).
//  in_last on the BLOCK_LEN-th sample is the same as a full block.
//  in_last on an empty block cannot occur, since in_last always rides on a transfer.
//  Reset during DRAIN discards the remaining words; no out_last is emitted for the aborted block.
// CONFIGURATION
//  SHFLOAT_ROUND_EN defined:
//   - adds 1 at bit (INPUT_DEPTH-1-MANTISSA_DEPTH) of v<<<exp before truncation;
//   - positive overflow saturates the mantissa to 0x7FF..;
//   - the exponent is unchanged.
//  SHFLOAT_ROUND_EN undefined: plain truncation (floor), no rounding logic generated.
// STRUCTURE
//  Package shfloat_pkg: state enum {FILL,NORM,DRAIN}; PACKED_DEPTH consistency check; bitlen/abs functions.
//  Sub-module shfloat_norm: combinational shift + mantissa extract + optional rounding/saturation.
//   One instance each for I and Q.
//  Top level holds the buffer array, count, mag_or, FSM and the output register.
// TESTING  (defaults, BLOCK_LEN=4)
//  4x {I=0x00000100,Q=0}, out_ready=1:
//   -> exp=22; 4 words 0x40000016; out_last on the 4th word; first valid 2 clk after the 4th accept.
//  4x {I=0,Q=0} -> 4 words 0x0000001F.
//  {I=0xFFFFFFFF,Q=0} with in_last:
//   -> one word 0x8000001F, out_last=1; in_ready returns 1 after it is accepted.
//  {I=0x40080000,Q=0} with in_last:
//   -> 0x40000000 without SHFLOAT_ROUND_EN; 0x40100000 with it.
//  {I=0x7FFFF800} with in_last and SHFLOAT_ROUND_EN:
//   -> saturates to 0x7FF00000 (no wrap to 0x800).
//  Backpressure and reset:
//   - out_ready low for 3 clk mid-DRAIN -> word held bit-identical and none lost;
//   - rst mid-DRAIN -> out_valid=0 next clk, next block packs cleanly.

Source files
------------

// File: rtl/shfloat_pkg.sv
// shfloat_pkg: shared state codes and helpers for the block-floating-point packer.
// Optional rounding is selected by SHFLOAT_ROUND_EN (see shfloat_norm).
package shfloat_pkg;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  function automatic bit packed_ok(
    input int p,
    input int m,
    input int e
  );
    return p == 2 * m + e;
  endfunction

  // One's-complement magnitude; callers sign-extend to 64 bits first.
  function automatic logic [63:0] abs1c(input logic [63:0] x);
    return x[63] ? ~x : x;
  endfunction

  // Position of the highest set bit plus one; zero for zero.
  function automatic logic [6:0] bitlen(input logic [63:0] x);
    logic [6:0] n;
    n = '0;
    for (int k = 0; k < 64; k++) begin
      if (x[k]) n = 7'(k + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/shfloat_norm.sv
// shfloat_norm: shift one component by the block exponent and keep the top bits.
// SHFLOAT_ROUND_EN adds round-half-up with positive saturation; default truncates.
module shfloat_norm #(
  parameter int IW = 32,
  parameter int MW = 12,
  parameter int EW = 8
) (
  input  logic [IW-1:0] value,
  input  logic [EW-1:0] shamt,
  output logic [MW-1:0] mant
);

  logic [IW-1:0] sh;

  assign sh = value << shamt;

`ifdef SHFLOAT_ROUND_EN
  localparam logic [IW:0] RND = (IW+1)'(1) << (IW - 1 - MW);

  logic [MW:0] top;
  logic        ovf;

  // Round at the first dropped bit; a positive carry into the sign saturates.
  assign top  = (MW+1)'(({sh[IW-1], sh} + RND) >> (IW - MW));
  assign ovf  = (top[MW:MW-1] == 2'b01);
  assign mant = ovf ? {1'b0, {(MW-1){1'b1}}} : top[MW-1:0];
`else
  assign mant = MW'(sh >> (IW - MW));
`endif

endmodule

// File: rtl/shfloat_block.sv
// shfloat_block: collects up to BLOCK_LEN I/Q pairs, shares one exponent, drains packed words.
// Define SHFLOAT_ROUND_EN for rounded mantissas; default build truncates.
module shfloat_block
  import shfloat_pkg::*;
#(
  parameter int INPUT_DEPTH    = 32,
  parameter int MANTISSA_DEPTH = 12,
  parameter int EXPONENT_DEPTH = 8,
  parameter int PACKED_DEPTH   = 32,
  parameter int INDEX_DEPTH    = 32,
  parameter int BLOCK_LEN      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INDEX_DEPTH-1:0]    in_index,
  input  logic [INPUT_DEPTH-1:0]    in_value_i,
  input  logic [INPUT_DEPTH-1:0]    in_value_q,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [INDEX_DEPTH-1:0]    out_index,
  output logic [PACKED_DEPTH-1:0]   out_pack,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXPONENT_DEPTH-1:0] out_exp
);

  localparam int AW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int CW   = $clog2(BLOCK_LEN + 1);
  localparam int EMAX = (1 << EXPONENT_DEPTH) - 1;

  generate
    if (!packed_ok(PACKED_DEPTH, MANTISSA_DEPTH, EXPONENT_DEPTH)) begin : g_bad_pack
      $error("PACKED_DEPTH must equal 2*MANTISSA_DEPTH+EXPONENT_DEPTH");
    end
  endgenerate

  logic [1:0]                state;
  logic [CW-1:0]             count;
  logic [CW-1:0]             rd;
  logic [INPUT_DEPTH-1:0]    mag_or;
  logic [INPUT_DEPTH-1:0]    abs_i;
  logic [INPUT_DEPTH-1:0]    abs_q;
  logic [EXPONENT_DEPTH-1:0] exp_q;
  logic [EXPONENT_DEPTH-1:0] exp_calc;
  int                        exp_int;

  logic [INDEX_DEPTH-1:0]    buf_idx [2**AW];
  logic [INPUT_DEPTH-1:0]    buf_i   [2**AW];
  logic [INPUT_DEPTH-1:0]    buf_q   [2**AW];

  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [MANTISSA_DEPTH-1:0] mant_i;
  logic [MANTISSA_DEPTH-1:0] mant_q;
  logic                      take;
  logic                      load;

  assign in_ready = (state == FILL);
  assign out_exp  = exp_q;
  assign wr_ptr   = count[AW-1:0];
  assign rd_ptr   = rd[AW-1:0];
  assign take     = in_valid && in_ready;
  assign load     = (!out_valid || out_ready) && (rd != count);

  assign abs_i = INPUT_DEPTH'(abs1c(64'($signed(in_value_i))));
  assign abs_q = INPUT_DEPTH'(abs1c(64'($signed(in_value_q))));

  // Headroom of the accumulated magnitude, clamped to the field width.
  always_comb begin
    exp_int = INPUT_DEPTH - 1 - int'(bitlen(64'(mag_or)));
    if (exp_int > EMAX) exp_int = EMAX;
    exp_calc = EXPONENT_DEPTH'(exp_int);
  end

  shfloat_norm #(
    .IW (INPUT_DEPTH),
    .MW (MANTISSA_DEPTH),
    .EW (EXPONENT_DEPTH)
  ) u_norm_i (
    .value (buf_i[rd_ptr]),
    .shamt (exp_q),
    .mant  (mant_i)
  );

  shfloat_norm #(
    .IW (INPUT_DEPTH),
    .MW (MANTISSA_DEPTH),
    .EW (EXPONENT_DEPTH)
  ) u_norm_q (
    .value (buf_q[rd_ptr]),
    .shamt (exp_q),
    .mant  (mant_q)
  );

  // Sample buffer; contents are don't-care until written in FILL.
  always_ff @(posedge clk) begin
    if (take) begin
      buf_idx[wr_ptr] <= in_index;
      buf_i[wr_ptr]   <= in_value_i;
      buf_q[wr_ptr]   <= in_value_q;
    end
  end

  // Block FSM plus the output register that drains the buffer in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      rd        <= '0;
      mag_or    <= '0;
      exp_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pack  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        FILL: begin
          if (take) begin
            count  <= count + 1'b1;
            mag_or <= mag_or | abs_i | abs_q;
            if (in_last || (count + 1'b1) == CW'(BLOCK_LEN)) state <= NORM;
          end
        end
        NORM: begin
          exp_q <= exp_calc;
          rd    <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (load) begin
            out_valid <= 1'b1;
            out_pack  <= {mant_i, mant_q, exp_q};
            out_index <= buf_idx[rd_ptr];
            out_last  <= ((rd + 1'b1) == count);
            rd        <= rd + 1'b1;
          end
          if (out_valid && out_ready && out_last) begin
            state  <= FILL;
            count  <= '0;
            mag_or <= '0;
            rd     <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_shfloat_block.sv
// tb_shfloat_block: scoreboard bench for the block-floating-point packer.
// Expected words come from literals and an independent reference model.
module tb_shfloat_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_index = '0;
  logic [31:0] in_value_i = '0;
  logic [31:0] in_value_q = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_index;
  logic [31:0] out_pack;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_exp;

  shfloat_block dut (
    .clk        (clk),
    .rst        (rst),
    .in_index   (in_index),
    .in_value_i (in_value_i),
    .in_value_q (in_value_q),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_index  (out_index),
    .out_pack   (out_pack),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] pk;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_words = 0;
  int          cyc = 0;
  int          close_cyc = 0;
  bit          lat_arm = 1'b0;
  logic [31:0] bi[4];
  logic [31:0] bq[4];
  logic [31:0] bx[4];
  logic [31:0] cap_pk;
  logic [31:0] cap_idx;
  logic        cap_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        cur = sb.pop_front();
        chk("pack", 64'(out_pack), 64'(cur.pk));
        chk("index", 64'(out_index), 64'(cur.idx));
        chk("last", 64'(out_last), 64'(cur.last));
        chk("exp", 64'(out_exp), 64'(cur.pk[7:0]));
        n_words++;
      end
    end
    if (lat_arm && out_valid) begin
      chk("latency", 64'(cyc - close_cyc), 64'd2);
      lat_arm = 1'b0;
    end
  end

  function automatic logic [11:0] ref_mant(input logic [31:0] v, input int e);
    logic [31:0] t;
    longint      s;
    t = v << e;
    s = longint'($signed(t));
`ifdef SHFLOAT_ROUND_EN
    s = s + 64'sd524288;
    if (s > 64'sd2147483647) return 12'h7FF;
`endif
    return 12'((s >>> 20) & 64'hFFF);
  endfunction

  function automatic logic [31:0] ref_abs(input logic [31:0] v);
    return v[31] ? ~v : v;
  endfunction

  task automatic push_lit(input logic [31:0] idx, input logic [31:0] pk, input logic last);
    exp_t e;
    e.idx = idx;
    e.pk = pk;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic push_model(input int n);
    logic [31:0] mag;
    logic [31:0] m;
    int          e;
    mag = '0;
    for (int k = 0; k < n; k++) mag = mag | ref_abs(bi[k]) | ref_abs(bq[k]);
    e = 31;
    m = mag;
    while (m != 0) begin
      m = m >> 1;
      e--;
    end
    for (int k = 0; k < n; k++)
      push_lit(bx[k], {ref_mant(bi[k], e), ref_mant(bq[k], e), 8'(e)}, k == n - 1);
  endtask

  task automatic send(input logic [31:0] idx, input logic [31:0] vi,
                      input logic [31:0] vq, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_index = idx;
    in_value_i = vi;
    in_value_q = vq;
    in_last = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    close_cyc = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic fill_random(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      bx[k] = 32'(base + k);
      bi[k] = 32'($signed($urandom) >>> $urandom_range(0, 31));
      bq[k] = 32'($signed($urandom) >>> $urandom_range(0, 31));
    end
  endtask

  task automatic run_model(input int n, input int base, input bit force_last);
    fill_random(n, base);
    push_model(n);
    for (int k = 0; k < n; k++)
      send(bx[k], bi[k], bq[k], (k == n - 1) && (n < 4 || force_last));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_pack", 64'(out_pack), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_exp", 64'(out_exp), 64'd0);

    for (int k = 0; k < 4; k++) push_lit(32'(10 + k), 32'h40000016, k == 3);
    for (int k = 0; k < 4; k++) send(32'(10 + k), 32'h00000100, 32'h0, 1'b0);
    lat_arm = 1'b1;
    wait_empty();

    for (int k = 0; k < 4; k++) push_lit(32'(20 + k), 32'h0000001F, k == 3);
    for (int k = 0; k < 4; k++) send(32'(20 + k), 32'h0, 32'h0, 1'b0);
    wait_empty();

    push_lit(32'd30, 32'h8000001F, 1'b1);
    send(32'd30, 32'hFFFFFFFF, 32'h0, 1'b1);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    wait_empty();
    chk("free_in_ready", 64'(in_ready), 64'd1);

`ifdef SHFLOAT_ROUND_EN
    push_lit(32'd31, 32'h40100000, 1'b1);
`else
    push_lit(32'd31, 32'h40000000, 1'b1);
`endif
    send(32'd31, 32'h40080000, 32'h0, 1'b1);
    wait_empty();

    push_lit(32'd32, 32'h7FF00000, 1'b1);
    send(32'd32, 32'h7FFFF800, 32'h0, 1'b1);
    wait_empty();

    for (int b = 0; b < 24; b++) begin
      run_model($urandom_range(1, 4), 100 + 8 * b, 1'($urandom_range(0, 1)));
      wait_empty();
    end

    run_model(4, 500, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    cap_pk = out_pack;
    cap_idx = out_index;
    cap_last = out_last;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_pack", 64'(out_pack), 64'(cap_pk));
      chk("hold_index", 64'(out_index), 64'(cap_idx));
      chk("hold_last", 64'(out_last), 64'(cap_last));
    end
    out_ready = 1'b1;
    wait_empty();

    run_model(4, 600, 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_last", 64'(out_last), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);

    run_model(3, 700, 1'b0);
    wait_empty();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("words_seen", 64'(n_words > 20), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
